raw_capture: RTL

//  Upstream stage of the image-processing path. Qualifies raw 12-bit sensor pixels with frame/line valid,

---
 rtl/capture_pkg.sv | 19 +
 rtl/raw_capture_if.sv | 39 +++
 rtl/capture_edge_det.sv | 20 ++
 rtl/raw_capture.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared widths, FSM state type and coordinate helper for the raw sensor capture stage.
package capture_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned COORD_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } cap_state_t;

  // Increment that stops at lim, so rows never run past the last active line.
  function automatic logic [COORD_W-1:0] satInc(input logic [COORD_W-1:0] v,
                                                input logic [COORD_W-1:0] lim);
    return (v >= lim) ? lim : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/raw_capture_if.sv
// Sensor-side and image-processor-side signals of raw_capture.
// iTEST_MODE exists only when TEST_PATTERN_EN is defined.
interface raw_capture_if #(
  parameter int unsigned FRAME_CNT_W = 32
) ();
  import capture_pkg::*;

  logic [DATA_W-1:0]      iDATA;
  logic                   iFVAL;
  logic                   iLVAL;
  logic                   iSTART;
  logic                   iEND;
`ifdef TEST_PATTERN_EN
  logic                   iTEST_MODE;
`endif
  logic [DATA_W-1:0]      oDATA;
  logic                   oDVAL;
  logic [COORD_W-1:0]     oX_Cont;
  logic [COORD_W-1:0]     oY_Cont;
  logic [FRAME_CNT_W-1:0] oFrame_Cont;
  logic                   oBusy;

  modport master (
`ifdef TEST_PATTERN_EN
    output iTEST_MODE,
`endif
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
  );

  modport slave (
`ifdef TEST_PATTERN_EN
    input  iTEST_MODE,
`endif
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
  );

endinterface

// File: rtl/capture_edge_det.sv
// Rise/fall detector against a registered previous-cycle copy of sig.
module capture_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise_c,
  output logic fall_c
);

  logic sigQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sigQ <= 1'b0;
    else     sigQ <= sig;
  end

  assign rise_c = sig & ~sigQ;
  assign fall_c = ~sig & sigQ;

endmodule

// File: rtl/raw_capture.sv
// Qualifies raw sensor pixels with FVAL/LVAL, gates capture by start/stop and tracks X/Y/frame count.
// Build option TEST_PATTERN_EN adds iTEST_MODE, replacing pixel data with (X+Y).
module raw_capture #(
  parameter int unsigned H_WIDTH     = 1280,
  parameter int unsigned V_HEIGHT    = 960,
  parameter int unsigned FRAME_CNT_W = 32
) (
  input  logic          iCLK,
  input  logic          iRST,
  raw_capture_if.slave  bus
);
  import capture_pkg::*;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_HEIGHT - 1);

  logic [DATA_W-1:0]  rDATA;
  logic               rFVAL;
  logic               rLVAL;
  logic               fvalRise;
  logic               fvalFall;
  logic               lvalRise;
  logic               lvalFall;
  logic               pixValid;
  cap_state_t         state;
  logic               stopPending;
  logic [COORD_W-1:0] xCnt;
  logic [COORD_W-1:0] yCnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rDATA <= '0;
      rFVAL <= 1'b0;
      rLVAL <= 1'b0;
    end else begin
      rDATA <= bus.iDATA;
      rFVAL <= bus.iFVAL;
      rLVAL <= bus.iLVAL;
    end
  end

  capture_edge_det uFvalEdge (
    .clk    (iCLK),
    .rst    (iRST),
    .sig    (rFVAL),
    .rise_c (fvalRise),
    .fall_c (fvalFall)
  );

  capture_edge_det uLvalEdge (
    .clk    (iCLK),
    .rst    (iRST),
    .sig    (rLVAL),
    .rise_c (lvalRise),
    .fall_c (lvalFall)
  );

  // iEND takes priority over iSTART; a stop seen mid-frame waits for the frame to end.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state           <= IDLE;
      stopPending     <= 1'b0;
      bus.oBusy       <= 1'b0;
      bus.oFrame_Cont <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.iEND && bus.iSTART) begin
            state     <= WAIT_FRAME;
            bus.oBusy <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (bus.iEND) begin
            state     <= IDLE;
            bus.oBusy <= 1'b0;
          end else if (fvalRise) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (fvalFall) begin
            bus.oFrame_Cont <= bus.oFrame_Cont + FRAME_CNT_W'(1);
            stopPending     <= 1'b0;
            if (stopPending || bus.iEND) begin
              state     <= IDLE;
              bus.oBusy <= 1'b0;
            end else begin
              state <= WAIT_FRAME;
            end
          end else if (bus.iEND) begin
            stopPending <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          stopPending <= 1'b0;
          bus.oBusy   <= 1'b0;
        end
      endcase
    end
  end

  assign pixValid = rFVAL & rLVAL & (state == CAPTURE);

  // xCnt/yCnt address the next pixel; the output copies are taken with each valid pixel.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oDVAL   <= 1'b0;
      bus.oDATA   <= '0;
      bus.oX_Cont <= '0;
      bus.oY_Cont <= '0;
      xCnt        <= '0;
      yCnt        <= '0;
    end else begin
      bus.oDVAL <= pixValid;
      if (pixValid) begin
`ifdef TEST_PATTERN_EN
        bus.oDATA <= bus.iTEST_MODE ? (DATA_W'(xCnt) + DATA_W'(yCnt)) : rDATA;
`else
        bus.oDATA <= rDATA;
`endif
        bus.oX_Cont <= xCnt;
        bus.oY_Cont <= yCnt;
        if (xCnt == X_LAST) begin
          xCnt <= '0;
          yCnt <= satInc(yCnt, Y_LAST);
        end else begin
          xCnt <= xCnt + COORD_W'(1);
        end
      end else if (lvalFall && (xCnt != '0)) begin
        xCnt <= '0;
        yCnt <= satInc(yCnt, Y_LAST);
      end else if (lvalRise) begin
        xCnt <= '0;
      end
      if (fvalRise) begin
        xCnt <= '0;
        yCnt <= '0;
      end
    end
  end

endmodule
